// File: rtl/lstm_step_driver.sv
// lstm_step_driver
//   Step sequencer for the LSTM core. Accepts one sample per time step,
//   keeps the recurrent h/c vectors in registers, starts the core, waits
//   for its done pulse, writes the results back as the next step's state
//   and presents the new hidden vector on an output stream.
//
//   Optional feature: define LSTM_DRV_TIMEOUT_EN to enable a watchdog on
//   the WAIT state. When undefined, WAIT is unbounded and timeout_err = 0.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and
//   ready are both high. in_ready is high only in IDLE. out_valid is high
//   only in OUTPUT, and out_h/out_last hold steady until out_ready.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        sample handshake; in_data, in_last payload
//   seq_clear                zero h/c state, step_count and timeout_err
//   lstm_start/lstm_done     core start pulse / core completion pulse
//   lstm_input_data          registered sample driven to the core
//   lstm_h_prev/lstm_c_prev  recurrent state registers driven to the core
//   lstm_h_next/lstm_c_next  core results, valid while lstm_done is high
//   out_valid/out_ready      result handshake; out_h, out_last payload
//   busy                     high whenever the FSM is not in IDLE
//   step_count               completed steps in this sequence (saturating)
//   timeout_err              sticky watchdog flag
//   dbg_state                current FSM state (0 IDLE,1 ISSUE,2 WAIT,3 OUTPUT)
module lstm_step_driver #(
    parameter int DATA_WIDTH     = 32,
    parameter int HIDDEN_SIZE    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_last,
    input  logic                              seq_clear,
    output logic                              lstm_start,
    input  logic                              lstm_done,
    output logic [DATA_WIDTH-1:0]             lstm_input_data,
    output logic [DATA_WIDTH*HIDDEN_SIZE-1:0] lstm_h_prev,
    output logic [DATA_WIDTH*HIDDEN_SIZE-1:0] lstm_c_prev,
    input  logic [DATA_WIDTH*HIDDEN_SIZE-1:0] lstm_h_next,
    input  logic [DATA_WIDTH*HIDDEN_SIZE-1:0] lstm_c_next,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH*HIDDEN_SIZE-1:0] out_h,
    output logic                              out_last,
    output logic                              busy,
    output logic [15:0]                       step_count,
    output logic                              timeout_err,
    output logic [1:0]                        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic last_q;
    logic clear_pend;
    logic timed_out;
    logic accept, capture, out_hs, idle_clr, busy_clr, zero_state;

    assign accept   = (state == S_IDLE)   && in_valid;
    assign capture  = (state == S_WAIT)   && lstm_done;
    assign out_hs   = (state == S_OUTPUT) && out_ready;
    assign idle_clr = (state == S_IDLE)   && seq_clear;
    // A clear requested while busy, or arriving on the cycle the step ends.
    assign busy_clr = clear_pend || seq_clear;
    // The pending clear is applied once the in-flight step has finished,
    // after the core results have already been captured for the output.
    assign zero_state = idle_clr
                     || (out_hs && (last_q || busy_clr))
                     || (timed_out && busy_clr);

`ifdef LSTM_DRV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            clr_err;

    // wd_cnt counts completed WAIT cycles; the last allowed one fires.
    assign timed_out = (state == S_WAIT) && !lstm_done
                    && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign clr_err   = idle_clr || (out_hs && busy_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (timed_out) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (lstm_done) begin
                    state_nxt = S_OUTPUT;
                end else if (timed_out) begin
                    state_nxt = S_IDLE;
                end
            end
            S_OUTPUT: if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready   = (state == S_IDLE);
        lstm_start = (state == S_ISSUE);
        out_valid  = (state == S_OUTPUT);
        busy       = (state != S_IDLE);
        dbg_state  = state;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lstm_input_data <= '0;
            last_q          <= 1'b0;
            lstm_h_prev     <= '0;
            lstm_c_prev     <= '0;
            out_h           <= '0;
            out_last        <= 1'b0;
            step_count      <= '0;
            clear_pend      <= 1'b0;
        end else begin
            if (accept) begin
                lstm_input_data <= in_data;
                last_q          <= in_last;
            end

            if (capture) begin
                lstm_h_prev <= lstm_h_next;
                lstm_c_prev <= lstm_c_next;
                out_h       <= lstm_h_next;
                out_last    <= last_q;
            end else if (zero_state) begin
                lstm_h_prev <= '0;
                lstm_c_prev <= '0;
            end

            if (zero_state) begin
                step_count <= '0;
            end else if (out_hs && (step_count != 16'hFFFF)) begin
                step_count <= step_count + 16'd1;
            end

            if (out_hs || timed_out) begin
                clear_pend <= 1'b0;
            end else if ((state != S_IDLE) && seq_clear) begin
                clear_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lstm_step_driver.sv
// Self-checking bench for lstm_step_driver: a behavioural core model,
// driver tasks, an output scoreboard and a final summary line.
module tb_lstm_step_driver;

    localparam int DW = 32;
    localparam int HS = 16;
    localparam int VW = DW * HS;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          seq_clear;
    logic          lstm_start;
    logic          lstm_done;
    logic [DW-1:0] lstm_input_data;
    logic [VW-1:0] lstm_h_prev;
    logic [VW-1:0] lstm_c_prev;
    logic [VW-1:0] lstm_h_next;
    logic [VW-1:0] lstm_c_next;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_h;
    logic          out_last;
    logic          busy;
    logic [15:0]   step_count;
    logic          timeout_err;
    logic [1:0]    dbg_state;

    lstm_step_driver #(
        .DATA_WIDTH     (DW),
        .HIDDEN_SIZE    (HS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .seq_clear       (seq_clear),
        .lstm_start      (lstm_start),
        .lstm_done       (lstm_done),
        .lstm_input_data (lstm_input_data),
        .lstm_h_prev     (lstm_h_prev),
        .lstm_c_prev     (lstm_c_prev),
        .lstm_h_next     (lstm_h_next),
        .lstm_c_next     (lstm_c_next),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_h           (out_h),
        .out_last        (out_last),
        .busy            (busy),
        .step_count      (step_count),
        .timeout_err     (timeout_err),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- core model ----------------
    function automatic logic [VW-1:0] all_of(input logic [DW-1:0] v);
        return {HS{v}};
    endfunction

    function automatic logic [VW-1:0] core_h(input logic [VW-1:0] hp, input logic [DW-1:0] x);
        logic [VW-1:0] r;
        for (int k = 0; k < HS; k++) r[k*DW +: DW] = hp[k*DW +: DW] + x + DW'(k);
        return r;
    endfunction

    function automatic logic [VW-1:0] core_c(input logic [VW-1:0] cp);
        logic [VW-1:0] r;
        for (int k = 0; k < HS; k++) r[k*DW +: DW] = cp[k*DW +: DW] + 32'h100;
        return r;
    endfunction

    int core_lat  = 5;
    bit core_mode = 1'b0;   // 0: constant 0x11/0x22, 1: state-dependent

    initial begin
        lstm_done   = 1'b0;
        lstm_h_next = '0;
        lstm_c_next = '0;
        forever begin
            @(negedge clk);
            if (lstm_start) begin
                repeat (core_lat) @(negedge clk);
                if (core_mode == 1'b0) begin
                    lstm_h_next = all_of(32'h11);
                    lstm_c_next = all_of(32'h22);
                end else begin
                    lstm_h_next = core_h(lstm_h_prev, lstm_input_data);
                    lstm_c_next = core_c(lstm_c_prev);
                end
                lstm_done = 1'b1;
                @(negedge clk);
                lstm_done = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int            n_out = 0;
    logic [VW-1:0] m_h, m_c;
    int            m_cnt;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", VW'(out_valid), VW'(0));
            end else begin
                check("out_h", out_h, exp_q.pop_front());
                check("out_last", VW'(out_last), VW'(exp_last_q.pop_front()));
                n_out++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DW-1:0] x, input logic last, input logic clr);
        logic [VW-1:0] eh, ec;
        for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
        check("send_ready", VW'(in_ready), VW'(1));
        if (clr) begin
            m_h = '0; m_c = '0; m_cnt = 0;
        end
        if (core_mode == 1'b0) begin
            eh = all_of(32'h11);
            ec = all_of(32'h22);
        end else begin
            eh = core_h(m_h, x);
            ec = core_c(m_c);
        end
        exp_q.push_back(eh);
        exp_last_q.push_back(last);
        if (last) begin
            m_h = '0; m_c = '0; m_cnt = 0;
        end else begin
            m_h = eh; m_c = ec;
            if (m_cnt < 65535) m_cnt++;
        end
        in_valid  = 1'b1;
        in_data   = x;
        in_last   = last;
        seq_clear = clr;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        seq_clear = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check(tag, VW'(busy), VW'(0));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_h"}, lstm_h_prev, m_h);
        check({tag, "_c"}, lstm_c_prev, m_c);
        check({tag, "_cnt"}, VW'(step_count), VW'(m_cnt));
    endtask

    // ---------------- main sequence ----------------
    int            start_cnt, start_cyc, out_cyc, n_before;
    logic [VW-1:0] snap, save_h, save_c;
    int            save_cnt;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        seq_clear = 1'b0; out_ready = 1'b1;
        m_h = '0; m_c = '0; m_cnt = 0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_in_ready", VW'(in_ready), VW'(1));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_start", VW'(lstm_start), VW'(0));
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_timeout", VW'(timeout_err), VW'(0));
        check_state("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // single step, cycle-accurate latency (cycle 0 = accept)
        core_mode = 1'b0;
        send(32'h3F000000, 1'b0, 1'b0);
        check("start_c1", VW'(lstm_start), VW'(1));
        check("input_data", VW'(lstm_input_data), VW'(32'h3F000000));
        start_cnt = 1; start_cyc = 1; out_cyc = 0;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            if (lstm_start) start_cnt++;
            if (out_valid && out_cyc == 0) out_cyc = c;
        end
        check("start_count", VW'(start_cnt), VW'(1));
        check("start_cyc", VW'(start_cyc), VW'(1));
        check("out_valid_cyc", VW'(out_cyc), VW'(7));
        check_state("step1");

        // seq_clear in IDLE
        seq_clear = 1'b1;
        @(negedge clk);
        seq_clear = 1'b0;
        m_h = '0; m_c = '0; m_cnt = 0;
        check_state("idle_clr");

        // three-sample sequence, last on the third
        core_mode = 1'b1;
        send(32'h100, 1'b0, 1'b0); wait_idle("seq1_idle"); check_state("seq1");
        send(32'h200, 1'b0, 1'b0); wait_idle("seq2_idle"); check_state("seq2");
        send(32'h300, 1'b1, 1'b0); wait_idle("seq3_idle"); check_state("seq3");

        // output backpressure for 10 cycles
        out_ready = 1'b0;
        n_before  = n_out;
        send(32'h400, 1'b0, 1'b0);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        check("bp_out_valid", VW'(out_valid), VW'(1));
        snap = out_h;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD;
            @(negedge clk);
            check("bp_stable", out_h, snap);
            check("bp_in_ready", VW'(in_ready), VW'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        wait_idle("bp_idle");
        check("bp_one_out", VW'(n_out), VW'(n_before + 1));
        check_state("bp");

        // seq_clear during WAIT: output still carries core results
        send(32'h500, 1'b0, 1'b0);
        @(negedge clk);
        seq_clear = 1'b1;
        @(negedge clk);
        seq_clear = 1'b0;
        m_h = '0; m_c = '0; m_cnt = 0;
        wait_idle("wclr_idle");
        check_state("wclr");

        // seq_clear coincident with accept: step sees zero state
        send(32'h600, 1'b0, 1'b0); wait_idle("pre_idle");
        send(32'h700, 1'b0, 1'b1);
        check("coin_h_prev", lstm_h_prev, '0);
        check("coin_c_prev", lstm_c_prev, '0);
        wait_idle("coin_idle");
        check_state("coin");

        // core slow to answer
        core_lat = 100;
        save_h = m_h; save_c = m_c; save_cnt = m_cnt;
        send(32'h800, 1'b0, 1'b0);
`ifdef LSTM_DRV_TIMEOUT_EN
        void'(exp_q.pop_back());
        void'(exp_last_q.pop_back());
        m_h = save_h; m_c = save_c; m_cnt = save_cnt;
        for (int c = 2; c <= TO + 2; c++) begin
            @(negedge clk);
            if (c == TO) begin
                check("to_early_err", VW'(timeout_err), VW'(0));
                check("to_early_busy", VW'(busy), VW'(1));
            end
        end
        check("to_err", VW'(timeout_err), VW'(1));
        check("to_busy", VW'(busy), VW'(0));
        repeat (50) @(negedge clk);
        check_state("to");
        seq_clear = 1'b1;
        @(negedge clk);
        seq_clear = 1'b0;
        m_h = '0; m_c = '0; m_cnt = 0;
        check("to_clr", VW'(timeout_err), VW'(0));
`else
        repeat (90) @(negedge clk);
        check("slow_busy", VW'(busy), VW'(1));
        check("slow_err", VW'(timeout_err), VW'(0));
        check("slow_no_out", VW'(out_valid), VW'(0));
        wait_idle("slow_idle");
        check_state("slow");
`endif

        // reset during WAIT; late done must be ignored
        core_lat = 20;
        send(32'h900, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_last_q.delete();
        m_h = '0; m_c = '0; m_cnt = 0;
        check("ar_in_ready", VW'(in_ready), VW'(1));
        check("ar_busy", VW'(busy), VW'(0));
        check("ar_start", VW'(lstm_start), VW'(0));
        check("ar_input", VW'(lstm_input_data), VW'(0));
        check("ar_out_h", out_h, '0);
        check_state("ar");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("late_busy", VW'(busy), VW'(0));
        check_state("late");

        // normal operation after reset
        core_lat = 5;
        send(32'hA00, 1'b1, 1'b0);
        wait_idle("final_idle");
        check_state("final");
        check("sb_empty", VW'(exp_q.size()), VW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lstm_step_driver.md
# lstm_step_driver

Sequencing initiator for the LSTM core. It accepts one input sample per time step on a valid/ready stream and holds the recurrent h/c state in registers. For each sample it issues a start pulse to the core, waits for done, writes h_next/c_next back as the next step's h_prev/c_prev, and presents h_next on an output stream. It sits between the sample source (DMA/sensor front-end) and the classifier head.

## Interface
- DATA_WIDTH, 32, element width.
- HIDDEN_SIZE, 16, hidden vector length; vector buses are flat, element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT; valid range ≥2.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid / in_ready  in / out  1  sample handshake.
- in_data  in  DATA_WIDTH  input sample.
- in_last  in  1  final sample of the sequence.
- seq_clear  in  1  zero h/c state, step_count and timeout_err.
- lstm_start  out  1  one-cycle start pulse to the core.
- lstm_done  in  1  core completion pulse; lstm_h_next/lstm_c_next are valid while it is high.
- lstm_input_data  out  DATA_WIDTH  registered sample driven to the core.
- lstm_h_prev, lstm_c_prev  out  DATA_WIDTH*HIDDEN_SIZE  state registers driven to the core.
- lstm_h_next, lstm_c_next  in  DATA_WIDTH*HIDDEN_SIZE  core results.
- out_valid / out_ready  out / in  1  result handshake.
- out_h  out  DATA_WIDTH*HIDDEN_SIZE  hidden vector of the completed step.
- out_last  out  1  copy of in_last for this step.
- busy  out  1  state != IDLE.
- step_count  out  16  completed steps in the current sequence; saturates at 0xFFFF.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUTPUT.
- IDLE:
  - in_ready = 1.
  - On in_valid&in_ready: latch in_data into lstm_input_data and in_last into last_q; go to ISSUE.
- ISSUE:
  - lstm_start = 1 for exactly this cycle.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - On lstm_done: h_state←lstm_h_next, c_state←lstm_c_next, out_h←lstm_h_next, out_last←last_q; go to OUTPUT.
  - lstm_done outside WAIT is ignored.
- OUTPUT:
  - out_valid = 1; out_h and out_last are held stable until out_ready.
  - On the handshake: if last_q, zero h_state, c_state and step_count; else increment step_count (saturating). Go to IDLE.
- seq_clear:
  - In IDLE: zeroes state the same edge. If in_valid is accepted in the same cycle, that step uses zero state.
  - While busy: recorded as pending and applied at the OUTPUT handshake, after capture. The in-flight step completes normally.
- Arithmetic: none. The block only moves registers; widths pass through unchanged.

## Timing
- Reset values: in_ready=1 (state IDLE); all other outputs, state registers, step_count and timeout_err = 0. Inputs are ignored while rst_n is low.
- Sample accepted at cycle 0 → lstm_start high in cycle 1 → capture on the cycle lstm_done is high → out_valid high the following cycle.
- With the LSTM core's 5-cycle start-to-done, lstm_done is in cycle 6 and out_valid in cycle 7.
- in_ready reasserts the cycle after the out handshake. Minimum step period = done latency + 3 cycles when out_ready is held high.
- lstm_h_prev/lstm_c_prev are stable from ISSUE through WAIT.
- Reset mid-operation: immediate return to IDLE, lstm_start drops, state is zeroed. The core shares rst_n.

## Configuration
- LSTM_DRV_TIMEOUT_EN defined:
  - If WAIT lasts TIMEOUT_CYCLES cycles without lstm_done, set timeout_err (sticky) and return to IDLE.
  - No state update, no output, step_count unchanged.
- LSTM_DRV_TIMEOUT_EN undefined: WAIT is unbounded and timeout_err is tied to 0.

## Test plan
- Reset, then one sample 0x3F000000 with a core model returning done after 5 cycles (h_next=all 0x11, c_next=all 0x22) → lstm_start in cycle 1 only; out_valid in cycle 7 with out_h=all 0x11; next lstm_h_prev=all 0x11, lstm_c_prev=all 0x22.
- Three samples, the third with in_last, out_ready always 1 → step_count 1, 2, then 0 after the third handshake; h/c state zero afterwards; out_last set only on the third output.
- out_ready held 0 for 10 cycles in OUTPUT → out_h stable, in_ready=0, in_valid ignored; on release the output is taken once.
- seq_clear pulsed during WAIT → current output still carries core results; state reads zero after the handshake. seq_clear coincident with an IDLE accept → that step sees zero h_prev.
- LSTM_DRV_TIMEOUT_EN with the core never asserting done → timeout_err=1 at cycle 1+TIMEOUT_CYCLES; busy=0; no out_valid; state unchanged. seq_clear clears timeout_err.
- rst_n asserted during WAIT → all outputs return to reset values asynchronously; a late lstm_done after reset is ignored.
